// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory bus bundle for mem_port_arbiter
// Signals: fetch port (if_req/if_addr -> if_gnt/if_rvalid/if_rdata),
//          data port (dm_req/dm_we/dm_addr/dm_wdata -> dm_gnt/dm_rvalid/dm_rdata),
//          memory port (mem_read/mem_write/mem_addr/mem_wdata <- mem_rdata).
// Modports: slave = arbiter view, master = requesters + memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter and sequencer for a single-port word memory
// Ports: clk, rst_n (async, active-low), bus (mem_port_arbiter_if.slave).
// Option: MEM_ARB_ROUND_ROBIN_EN selects a 1-bit round-robin pointer instead of
//         data-first priority with a fetch starvation counter.
// Every output is a flop; IDLE -> ISSUE -> RESP, with RESP able to go straight to ISSUE.
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched winner of the transaction in flight.
    logic r_win_if;
    logic r_we;

    logic              r_if_gnt, r_if_rvalid, r_dm_gnt, r_dm_rvalid, r_mem_read, r_mem_write;
    logic [DATA_W-1:0] r_if_rdata, r_dm_rdata, r_mem_wdata;
    logic [ADDR_W-1:0] r_mem_addr;

    logic              w_if_gnt_nxt, w_if_rvalid_nxt, w_dm_gnt_nxt, w_dm_rvalid_nxt;
    logic              w_mem_read_nxt, w_mem_write_nxt;
    logic [DATA_W-1:0] w_if_rdata_nxt, w_dm_rdata_nxt, w_mem_wdata_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;

    logic w_arb;          // an arbitration takes place at this edge
    logic w_fetch_first;  // fetch wins a tie
    logic w_pick_if;

    // Requests are ignored during ISSUE; IDLE and RESP both arbitrate.
    assign w_arb     = (r_state != S_ISSUE) && (bus.if_req || bus.dm_req);
    assign w_pick_if = bus.if_req && (!bus.dm_req || w_fetch_first);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_rr_if;  // 1: fetch is preferred on the next tie

    assign w_fetch_first = r_rr_if;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_if <= 1'b0;
        end else if (w_arb) begin
            r_rr_if <= !w_pick_if;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve;  // consecutive arbitrations fetch requested and lost

    assign w_fetch_first = (r_starve == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= 4'd0;
        end else if (w_arb) begin
            if (w_pick_if) begin
                r_starve <= 4'd0;
            end else if (bus.if_req && (r_starve != LIMIT)) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = w_arb ? S_ISSUE : S_IDLE;
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = w_arb ? S_ISSUE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Computes the value every output flop takes at the coming edge.
    always_comb begin
        w_if_gnt_nxt    = 1'b0;
        w_dm_gnt_nxt    = 1'b0;
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
        w_if_rvalid_nxt = 1'b0;
        w_dm_rvalid_nxt = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        if (w_state_nxt == S_ISSUE) begin
            if (w_pick_if) begin
                w_if_gnt_nxt   = 1'b1;
                w_mem_read_nxt = 1'b1;
                w_mem_addr_nxt = bus.if_addr;
            end else begin
                w_dm_gnt_nxt    = 1'b1;
                w_mem_read_nxt  = !bus.dm_we;
                w_mem_write_nxt = bus.dm_we;
                w_mem_addr_nxt  = bus.dm_addr;
                w_mem_wdata_nxt = bus.dm_wdata;
            end
        end
        // Memory data is valid during RESP; the response pulse lands in the next cycle.
        if (r_state == S_RESP) begin
            if (r_win_if) begin
                w_if_rvalid_nxt = 1'b1;
                w_if_rdata_nxt  = bus.mem_rdata;
            end else begin
                w_dm_rvalid_nxt = 1'b1;
                if (!r_we) begin
                    w_dm_rdata_nxt = bus.mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_if    <= 1'b0;
            r_we        <= 1'b0;
            r_if_gnt    <= 1'b0;
            r_dm_gnt    <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            if (w_state_nxt == S_ISSUE) begin
                r_win_if <= w_pick_if;
                r_we     <= !w_pick_if && bus.dm_we;
            end
            r_if_gnt    <= w_if_gnt_nxt;
            r_dm_gnt    <= w_dm_gnt_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_if_rvalid <= w_if_rvalid_nxt;
            r_dm_rvalid <= w_dm_rvalid_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
        end
    end

    assign bus.if_gnt    = r_if_gnt;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_gnt    = r_dm_gnt;
    assign bus.dm_rvalid = r_dm_rvalid;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [31:0] wdata;
        int          gap;
    } req_t;

    typedef struct {
        int          gnt_cyc;
        logic [7:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] data;
    } exp_t;

    req_t f_q[$];
    req_t d_q[$];
    exp_t eg_if[$];
    exp_t er_if[$];
    exp_t eg_dm[$];
    exp_t er_dm[$];
    byte  grant_log[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int rv_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Memory block: samples strobes mid-cycle, acts on the rising edge, read data one cycle later.
    logic [7:0] mem [256];
    initial begin : mem_model
        logic        rd_p;
        logic        wr_p;
        logic [7:0]  a;
        logic [7:0]  ak;
        logic [31:0] wd;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            rd_p = bus.mem_read;
            wr_p = bus.mem_write;
            a    = bus.mem_addr;
            wd   = bus.mem_wdata;
            @(posedge clk);
            if (rst_n) begin
                if (wr_p) begin
                    for (int k = 0; k < 4; k++) begin
                        ak = a + 8'(k);
                        mem[ak] = wd[31 - 8 * k -: 8];
                    end
                end
                if (rd_p) bus.mem_rdata <= {mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)], mem[8'(a + 8'd3)]};
            end
        end
    end

    // Reference model: transaction-level arbiter over a byte-array memory.
    logic [7:0]  ref_mem [256];
    logic [31:0] ref_dm_rdata = '0;
    int          next_arb = 0;
    int          losses = 0;
    bit          rr_fetch = 1'b0;

    function automatic logic [31:0] ref_rd(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
        return {ref_mem[a], ref_mem[a1], ref_mem[a2], ref_mem[a3]};
    endfunction

    initial begin : ref_model
        exp_t       e;
        bit         fw;
        logic [7:0] ak;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                next_arb = 0; losses = 0; rr_fetch = 1'b0; ref_dm_rdata = '0;
                eg_if.delete(); er_if.delete(); eg_dm.delete(); er_dm.delete();
            end else if (cyc >= next_arb && (bus.if_req || bus.dm_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                fw = bus.if_req && (!bus.dm_req || rr_fetch);
                rr_fetch = !fw;
`else
                fw = bus.if_req && (!bus.dm_req || losses == STARVE_LIMIT);
                if (fw) losses = 0;
                else if (bus.if_req && losses < STARVE_LIMIT) losses++;
`endif
                e.gnt_cyc = cyc;
                if (fw) begin
                    e.addr = bus.if_addr; e.we = 1'b0; e.wdata = '0;
                    e.data = ref_rd(bus.if_addr);
                    eg_if.push_back(e); er_if.push_back(e);
                end else begin
                    e.addr = bus.dm_addr; e.we = bus.dm_we; e.wdata = bus.dm_wdata;
                    if (bus.dm_we) begin
                        for (int k = 0; k < 4; k++) begin
                            ak = bus.dm_addr + 8'(k);
                            ref_mem[ak] = bus.dm_wdata[31 - 8 * k -: 8];
                        end
                        e.data = ref_dm_rdata;
                    end else begin
                        e.data = ref_rd(bus.dm_addr);
                        ref_dm_rdata = e.data;
                    end
                    eg_dm.push_back(e); er_dm.push_back(e);
                end
                next_arb = cyc + 2;
            end
        end
    end

    // Fetch requester: holds req until gnt, chains the next item when its gap is zero.
    initial begin : fetch_drv
        bus.if_req = 1'b0; bus.if_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.if_req = 1'b0;
            end else if (bus.if_req && bus.if_gnt) begin
                if (f_q.size() > 0) void'(f_q.pop_front());
                if (f_q.size() > 0 && f_q[0].gap == 0) bus.if_addr = f_q[0].addr;
                else bus.if_req = 1'b0;
            end else if (bus.if_req) begin
                if (f_q.size() == 0) bus.if_req = 1'b0;
            end else if (f_q.size() > 0) begin
                if (f_q[0].gap > 0) f_q[0].gap = f_q[0].gap - 1;
                else begin bus.if_req = 1'b1; bus.if_addr = f_q[0].addr; end
            end
        end
    end

    initial begin : data_drv
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.dm_req = 1'b0;
            end else if (bus.dm_req && bus.dm_gnt) begin
                if (d_q.size() > 0) void'(d_q.pop_front());
                if (d_q.size() > 0 && d_q[0].gap == 0) begin
                    bus.dm_we = d_q[0].we; bus.dm_addr = d_q[0].addr; bus.dm_wdata = d_q[0].wdata;
                end else bus.dm_req = 1'b0;
            end else if (bus.dm_req) begin
                if (d_q.size() == 0) bus.dm_req = 1'b0;
            end else if (d_q.size() > 0) begin
                if (d_q[0].gap > 0) d_q[0].gap = d_q[0].gap - 1;
                else begin
                    bus.dm_req = 1'b1; bus.dm_we = d_q[0].we;
                    bus.dm_addr = d_q[0].addr; bus.dm_wdata = d_q[0].wdata;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a grant or a response.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.if_rvalid || bus.dm_rvalid) rv_seen++;
            if (rst_n) begin
                if (bus.mem_read || bus.mem_write) chk("strobe_excl", bus.mem_read & bus.mem_write, 0);
                if (bus.if_gnt || bus.dm_gnt) chk("gnt_excl", bus.if_gnt & bus.dm_gnt, 0);
                while (eg_if.size() > 0 && eg_if[0].gnt_cyc < cyc) begin
                    e = eg_if.pop_front(); chk("if_gnt_missing_cyc", cyc, e.gnt_cyc);
                end
                while (eg_dm.size() > 0 && eg_dm[0].gnt_cyc < cyc) begin
                    e = eg_dm.pop_front(); chk("dm_gnt_missing_cyc", cyc, e.gnt_cyc);
                end
                while (er_if.size() > 0 && er_if[0].gnt_cyc + 2 < cyc) begin
                    e = er_if.pop_front(); chk("if_rvalid_missing_cyc", cyc, e.gnt_cyc + 2);
                end
                while (er_dm.size() > 0 && er_dm[0].gnt_cyc + 2 < cyc) begin
                    e = er_dm.pop_front(); chk("dm_rvalid_missing_cyc", cyc, e.gnt_cyc + 2);
                end
                if (bus.if_gnt) begin
                    grant_log.push_back(8'h46);
                    if (eg_if.size() == 0) chk("if_gnt_unexpected", bus.if_gnt, 0);
                    else begin
                        e = eg_if.pop_front();
                        chk("if_gnt_cycle", cyc, e.gnt_cyc);
                        chk("if_strobes", {bus.mem_read, bus.mem_write}, 2'b10);
                        chk("if_mem_addr", bus.mem_addr, e.addr);
                    end
                end
                if (bus.dm_gnt) begin
                    grant_log.push_back(8'h44);
                    if (eg_dm.size() == 0) chk("dm_gnt_unexpected", bus.dm_gnt, 0);
                    else begin
                        e = eg_dm.pop_front();
                        chk("dm_gnt_cycle", cyc, e.gnt_cyc);
                        chk("dm_strobes", {bus.mem_read, bus.mem_write}, {!e.we, e.we});
                        chk("dm_mem_addr", bus.mem_addr, e.addr);
                        if (e.we) chk("dm_mem_wdata", bus.mem_wdata, e.wdata);
                    end
                end
                if (bus.if_rvalid) begin
                    if (er_if.size() == 0) chk("if_rvalid_unexpected", bus.if_rvalid, 0);
                    else begin
                        e = er_if.pop_front();
                        chk("if_rvalid_cycle", cyc, e.gnt_cyc + 2);
                        chk("if_rdata", bus.if_rdata, e.data);
                    end
                end
                if (bus.dm_rvalid) begin
                    if (er_dm.size() == 0) chk("dm_rvalid_unexpected", bus.dm_rvalid, 0);
                    else begin
                        e = er_dm.pop_front();
                        chk("dm_rvalid_cycle", cyc, e.gnt_cyc + 2);
                        chk("dm_rdata", bus.dm_rdata, e.data);
                    end
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {bus.if_gnt, bus.if_rvalid, bus.dm_gnt, bus.dm_rvalid, bus.mem_read, bus.mem_write}, 0);
        chk({tag, "_rdata"}, {bus.if_rdata, bus.dm_rdata}, 0);
        chk({tag, "_mem"}, {bus.mem_addr, bus.mem_wdata}, 0);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            done = f_q.size() == 0 && d_q.size() == 0 && !bus.if_req && !bus.dm_req &&
                   eg_if.size() == 0 && er_if.size() == 0 && eg_dm.size() == 0 && er_dm.size() == 0;
        end
        chk({tag, "_drained"}, done, 1);
        if (!done) begin f_q.delete(); d_q.delete(); end
        repeat (2) @(negedge clk);
    endtask

    task automatic push_f(input logic [7:0] a, input int gap);
        f_q.push_back('{addr: a, we: 1'b0, wdata: 32'h0, gap: gap});
    endtask

    task automatic push_d(input logic we, input logic [7:0] a, input logic [31:0] wd, input int gap);
        d_q.push_back('{addr: a, we: we, wdata: wd, gap: gap});
    endtask

    initial begin : main
        string exp_seq;
        int    base;
        int    rv_base;
        bit    got;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        @(posedge clk); push_d(1'b1, 8'h10, 32'h11223344, 0);
        wait_idle("preload10");
        @(posedge clk); push_f(8'h10, 0);
        wait_idle("fetch10");
        chk("fetch10_value", bus.if_rdata, 32'h11223344);

        @(posedge clk); push_d(1'b1, 8'h20, 32'hDEADBEEF, 0); push_d(1'b0, 8'h20, 32'h0, 1);
        wait_idle("wr_rd20");
        chk("read20_value", bus.dm_rdata, 32'hDEADBEEF);

        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            push_f(8'($urandom), int'($urandom_range(0, 3)));
            push_d(1'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 3)));
        end
        wait_idle("random");

        @(posedge clk); push_d(1'b1, 8'hFE, 32'hAABBCCDD, 0);
        wait_idle("preloadFE");
        @(posedge clk); push_f(8'hFE, 0);
        wait_idle("fetchFE");
        chk("wrap_value", bus.if_rdata, 32'hAABBCCDD);

        @(posedge clk);
        base = grant_log.size();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq = "DFDFDFDFDF";
        for (int i = 0; i < 5; i++) begin push_d(1'b0, 8'($urandom), 32'h0, 0); push_f(8'($urandom), 0); end
`else
        exp_seq = "DDDDFDDDDF";
        for (int i = 0; i < 8; i++) push_d(1'b0, 8'($urandom), 32'h0, 0);
        for (int i = 0; i < 2; i++) push_f(8'($urandom), 0);
`endif
        wait_idle("saturated");
        for (int i = 0; i < 10; i++)
            chk("grant_order", (base + i < grant_log.size()) ? grant_log[base + i] : 8'h3F, exp_seq[i]);

        @(posedge clk); push_f(8'h10, 0);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus.if_gnt;
        end
        chk("midop_gnt_seen", got, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midop_reset");
        rv_base = rv_seen;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_rvalid_after_reset", rv_seen - rv_base, 0);

        @(posedge clk); push_f(8'hFE, 0);
        wait_idle("post_reset");
        chk("post_reset_value", bus.if_rdata, 32'hAABBCCDD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
